// File: rtl/candle_pkg.sv
// Shared types and default sizing for the candle array controller.
// The optional burn timeout is enabled with the CANDLE_BURN_TIMEOUT_EN macro.
package candle_pkg;

  localparam int DEF_N_CANDLES   = 8;
  localparam int DEF_DELTA_W     = 4;
  localparam int DEF_BURN_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    ACT  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/candle_array_ctrl_if.sv
// Step/blow request bus and candle status outputs of candle_array_ctrl.
// The master modport is the requester; the slave modport is the controller.
interface candle_array_ctrl_if
  import candle_pkg::*;
#(
  parameter int N_CANDLES = DEF_N_CANDLES,
  parameter int DELTA_W   = DEF_DELTA_W
);

  localparam int POS_W = $clog2(N_CANDLES);
  localparam int LIT_W = $clog2(N_CANDLES + 1);

  logic               step;
  logic [DELTA_W-1:0] delta;
  logic               blow;
  logic               ready;
  logic [POS_W-1:0]   position;
  logic [N_CANDLES-1:0] candle_state;
  logic [LIT_W-1:0]   lit_count;

  modport master (
    output step, delta, blow,
    input  ready, position, candle_state, lit_count
  );

  modport slave (
    input  step, delta, blow,
    output ready, position, candle_state, lit_count
  );

endinterface

// File: rtl/candle_burn_timer.sv
// Per-candle burn countdown: load starts BURN_CYCLES, expire pulses on the last cycle.
// Only instantiated when CANDLE_BURN_TIMEOUT_EN is defined.
module candle_burn_timer #(
  parameter int BURN_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic clr_async,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(BURN_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // clear wins over load so blow/extinguish can never leave a timer armed
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = CNT_W'(BURN_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/candle_array_ctrl.sv
// Igniter walking a ring of candles: step moves by delta, then toggles the candle there.
// Define CANDLE_BURN_TIMEOUT_EN to auto-extinguish candles after BURN_CYCLES cycles.
module candle_array_ctrl
  import candle_pkg::*;
#(
  parameter int N_CANDLES   = DEF_N_CANDLES,
  parameter int DELTA_W     = DEF_DELTA_W,
  parameter int BURN_CYCLES = DEF_BURN_CYCLES
) (
  input  logic                 sys_clk,
  input  logic                 clr_async,
  candle_array_ctrl_if.slave   bus
);

  localparam int POS_W = $clog2(N_CANDLES);
  localparam int LIT_W = $clog2(N_CANDLES + 1);
  localparam int SUM_W = ((DELTA_W > POS_W) ? DELTA_W : POS_W) + 1;
  localparam logic [SUM_W-1:0] N_SUM = SUM_W'(N_CANDLES);

  ctrl_state_t          state_q, state_d;
  logic [DELTA_W-1:0]   delta_q, delta_d;
  logic [POS_W-1:0]     position_q, position_d;
  logic [N_CANDLES-1:0] candle_q, candle_d;

  logic                 act_fire;
  logic [SUM_W-1:0]     pos_sum;
  logic [POS_W-1:0]     pos_wrapped;
  logic [N_CANDLES-1:0] act_mask;
  logic [N_CANDLES-1:0] expire;
  logic [LIT_W-1:0]     lit_sum;

  // Full-width sum then a constant-divisor modulo keeps wrap exact for any N and delta
  assign pos_sum     = SUM_W'(position_q) + SUM_W'(delta_q);
  assign pos_wrapped = POS_W'(pos_sum % N_SUM);

  always_comb begin
    state_d    = state_q;
    delta_d    = delta_q;
    position_d = position_q;
    act_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.step) begin
          delta_d = bus.delta;
          state_d = MOVE;
        end
      end
      MOVE: begin
        position_d = pos_wrapped;
        state_d    = ACT;
      end
      ACT: begin
        act_fire = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_CANDLES; gi++) begin : g_act
      assign act_mask[gi] = act_fire && (position_q == POS_W'(gi));
    end
  endgenerate

  // Expiry clears first, then ACT toggles, then blow overrides everything
  always_comb begin
    candle_d = (candle_q & ~expire) ^ act_mask;
    candle_d = candle_d & ~(act_mask & candle_q);
    if (bus.blow) begin
      candle_d = '0;
    end
  end

`ifdef CANDLE_BURN_TIMEOUT_EN
  logic [N_CANDLES-1:0] tmr_load;
  logic [N_CANDLES-1:0] tmr_clear;

  generate
    for (genvar gi = 0; gi < N_CANDLES; gi++) begin : g_timer
      assign tmr_load[gi]  = act_mask[gi] && !candle_q[gi] && !bus.blow;
      assign tmr_clear[gi] = bus.blow || (act_mask[gi] && candle_q[gi]);

      candle_burn_timer #(
        .BURN_CYCLES (BURN_CYCLES)
      ) u_timer (
        .sys_clk   (sys_clk),
        .clr_async (clr_async),
        .load      (tmr_load[gi]),
        .clear     (tmr_clear[gi]),
        .expire    (expire[gi])
      );
    end
  endgenerate
`else
  assign expire = '0;
`endif

  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      state_q    <= IDLE;
      delta_q    <= '0;
      position_q <= '0;
      candle_q   <= '0;
    end else begin
      state_q    <= state_d;
      delta_q    <= delta_d;
      position_q <= position_d;
      candle_q   <= candle_d;
    end
  end

  always_comb begin
    lit_sum = '0;
    for (int i = 0; i < N_CANDLES; i++) begin
      lit_sum = lit_sum + LIT_W'(candle_q[i]);
    end
  end

  assign bus.ready        = (state_q == IDLE);
  assign bus.position     = position_q;
  assign bus.candle_state = candle_q;
  assign bus.lit_count    = lit_sum;

endmodule

// File: tb/tb_candle_array_ctrl.sv
// Directed bench for candle_array_ctrl: N=8 and N=5 rings plus an N=8 ring with BURN_CYCLES=20.
// Burn expiry expectations follow whether CANDLE_BURN_TIMEOUT_EN is defined.
module tb_candle_array_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  candle_array_ctrl_if #(.N_CANDLES(8), .DELTA_W(4)) i8 ();
  candle_array_ctrl_if #(.N_CANDLES(5), .DELTA_W(4)) i5 ();
  candle_array_ctrl_if #(.N_CANDLES(8), .DELTA_W(4)) ib ();

  candle_array_ctrl #(.N_CANDLES(8), .DELTA_W(4)) dut8 (
    .sys_clk (clk), .clr_async (rst), .bus (i8)
  );
  candle_array_ctrl #(.N_CANDLES(5), .DELTA_W(4)) dut5 (
    .sys_clk (clk), .clr_async (rst), .bus (i5)
  );
  candle_array_ctrl #(.N_CANDLES(8), .DELTA_W(4), .BURN_CYCLES(20)) dutb (
    .sys_clk (clk), .clr_async (rst), .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_step(input int which, input logic v, input logic [3:0] d);
    case (which)
      0: begin i8.step = v; i8.delta = d; end
      1: begin i5.step = v; i5.delta = d; end
      default: begin ib.step = v; ib.delta = d; end
    endcase
  endtask

  // Returns one cycle after the edge that accepted step (FSM in MOVE)
  task automatic run_step(input int which, input logic [3:0] d);
    $display("step dut=%0d delta=%0d", which, d);
    set_step(which, 1'b1, d);
    tick();
    set_step(which, 1'b0, 4'd0);
  endtask

  task automatic run_full(input int which, input logic [3:0] d);
    run_step(which, d);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (i8.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", i8.ready); end
    checks++; if (i8.position !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0h expected 0", i8.position); end
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL reset_cs: got %0h expected 0", i8.candle_state); end
    checks++; if (i8.lit_count !== 4'd0) begin errors++; $display("FAIL reset_lit: got %0h expected 0", i8.lit_count); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_step();
    run_step(0, 4'd3);
    checks++; if (i8.ready !== 1'b0) begin errors++; $display("FAIL step_busy: got %0h expected 0", i8.ready); end
    checks++; if (i8.position !== 3'd0) begin errors++; $display("FAIL step_pos_t0: got %0h expected 0", i8.position); end
    tick();
    checks++; if (i8.position !== 3'd3) begin errors++; $display("FAIL step_pos_t1: got %0h expected 3", i8.position); end
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL step_cs_t1: got %0h expected 0", i8.candle_state); end
    tick();
    checks++; if (i8.candle_state !== 8'h08) begin errors++; $display("FAIL step_cs_t2: got %0h expected 08", i8.candle_state); end
    checks++; if (i8.lit_count !== 4'd1) begin errors++; $display("FAIL step_lit: got %0h expected 1", i8.lit_count); end
    checks++; if (i8.ready !== 1'b1) begin errors++; $display("FAIL step_ready: got %0h expected 1", i8.ready); end
    run_full(0, 4'd15);
    checks++; if (i8.position !== 3'd2) begin errors++; $display("FAIL step_wrap8_pos: got %0h expected 2", i8.position); end
    checks++; if (i8.candle_state !== 8'h0C) begin errors++; $display("FAIL step_wrap8_cs: got %0h expected 0c", i8.candle_state); end
    checks++; if (i8.lit_count !== 4'd2) begin errors++; $display("FAIL step_wrap8_lit: got %0h expected 2", i8.lit_count); end
  endtask

  task automatic test_toggle_ignore();
    pulse_reset();
    run_step(0, 4'd0);
    set_step(0, 1'b1, 4'd0);
    tick();
    set_step(0, 1'b0, 4'd0);
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL toggle_cs_t1: got %0h expected 0", i8.candle_state); end
    tick();
    checks++; if (i8.candle_state !== 8'h01) begin errors++; $display("FAIL toggle_lit: got %0h expected 01", i8.candle_state); end
    tick();
    checks++; if (i8.ready !== 1'b1) begin errors++; $display("FAIL toggle_not_queued: got %0h expected 1", i8.ready); end
    tick();
    tick();
    checks++; if (i8.candle_state !== 8'h01) begin errors++; $display("FAIL toggle_hold: got %0h expected 01", i8.candle_state); end
    run_full(0, 4'd0);
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL toggle_off: got %0h expected 0", i8.candle_state); end
    checks++; if (i8.lit_count !== 4'd0) begin errors++; $display("FAIL toggle_off_lit: got %0h expected 0", i8.lit_count); end
  endtask

  task automatic test_wrap5();
    run_full(1, 4'd4);
    checks++; if (i5.position !== 3'd4) begin errors++; $display("FAIL wrap5_pos4: got %0h expected 4", i5.position); end
    checks++; if (i5.candle_state !== 5'b10000) begin errors++; $display("FAIL wrap5_cs4: got %0h expected 10", i5.candle_state); end
    run_full(1, 4'd13);
    checks++; if (i5.position !== 3'd2) begin errors++; $display("FAIL wrap5_pos2: got %0h expected 2", i5.position); end
    checks++; if (i5.candle_state !== 5'b10100) begin errors++; $display("FAIL wrap5_cs2: got %0h expected 14", i5.candle_state); end
    checks++; if (i5.lit_count !== 3'd2) begin errors++; $display("FAIL wrap5_lit: got %0h expected 2", i5.lit_count); end
    run_full(1, 4'd15);
    checks++; if (i5.position !== 3'd2) begin errors++; $display("FAIL wrap5_pos15: got %0h expected 2", i5.position); end
    checks++; if (i5.candle_state !== 5'b10000) begin errors++; $display("FAIL wrap5_cs15: got %0h expected 10", i5.candle_state); end
  endtask

  task automatic test_blow();
    pulse_reset();
    run_full(0, 4'd0);
    run_full(0, 4'd2);
    checks++; if (i8.candle_state !== 8'h05) begin errors++; $display("FAIL blow_pre: got %0h expected 05", i8.candle_state); end
    run_step(0, 4'd3);
    tick();
    checks++; if (i8.position !== 3'd5) begin errors++; $display("FAIL blow_pos: got %0h expected 5", i8.position); end
    i8.blow = 1'b1;
    tick();
    i8.blow = 1'b0;
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL blow_act_cs: got %0h expected 0", i8.candle_state); end
    checks++; if (i8.lit_count !== 4'd0) begin errors++; $display("FAIL blow_act_lit: got %0h expected 0", i8.lit_count); end
    checks++; if (i8.ready !== 1'b1) begin errors++; $display("FAIL blow_ready: got %0h expected 1", i8.ready); end
    run_full(0, 4'd0);
    checks++; if (i8.candle_state !== 8'h20) begin errors++; $display("FAIL blow_relight: got %0h expected 20", i8.candle_state); end
    i8.blow = 1'b1;
    tick();
    i8.blow = 1'b0;
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL blow_idle: got %0h expected 0", i8.candle_state); end
  endtask

  task automatic test_reset_mid();
    run_full(0, 4'd0);
    checks++; if (i8.candle_state !== 8'h20) begin errors++; $display("FAIL rmid_pre: got %0h expected 20", i8.candle_state); end
    run_step(0, 4'd4);
    rst = 1'b1;
    #1;
    checks++; if (i8.ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0h expected 1", i8.ready); end
    checks++; if (i8.position !== 3'd0) begin errors++; $display("FAIL rmid_pos: got %0h expected 0", i8.position); end
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL rmid_cs: got %0h expected 0", i8.candle_state); end
    checks++; if (i8.lit_count !== 4'd0) begin errors++; $display("FAIL rmid_lit: got %0h expected 0", i8.lit_count); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (i8.candle_state !== 8'h00) begin errors++; $display("FAIL rmid_after_cs: got %0h expected 0", i8.candle_state); end
    checks++; if (i8.position !== 3'd0) begin errors++; $display("FAIL rmid_after_pos: got %0h expected 0", i8.position); end
  endtask

  task automatic test_burn();
    logic expect_bit;
`ifdef CANDLE_BURN_TIMEOUT_EN
    expect_bit = 1'b0;
`else
    expect_bit = 1'b1;
`endif
    run_full(2, 4'd1);
    checks++; if (ib.candle_state !== 8'h02) begin errors++; $display("FAIL burn_lit: got %0h expected 02", ib.candle_state); end
    for (int k = 1; k < 20; k++) tick();
    checks++; if (ib.candle_state[1] !== 1'b1) begin errors++; $display("FAIL burn_19: got %0h expected 1", ib.candle_state[1]); end
    tick();
    checks++; if (ib.candle_state[1] !== expect_bit) begin errors++; $display("FAIL burn_20: got %0h expected %0h", ib.candle_state[1], expect_bit); end
    checks++; if (ib.lit_count !== {3'd0, expect_bit}) begin errors++; $display("FAIL burn_20_lit: got %0h expected %0h", ib.lit_count, expect_bit); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    i8.step = 1'b0; i8.delta = '0; i8.blow = 1'b0;
    i5.step = 1'b0; i5.delta = '0; i5.blow = 1'b0;
    ib.step = 1'b0; ib.delta = '0; ib.blow = 1'b0;
    test_reset();
    test_step();
    test_toggle_ignore();
    test_wrap5();
    test_blow();
    test_reset_mid();
    test_burn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/candle_array_ctrl.md
CANDLE_ARRAY_CTRL -- requirements
Module: candle_array_ctrl

Interface
REQ-001 SHALL have parameter N_CANDLES, default 8, number of candles (2..32).
REQ-002 SHALL have parameter DELTA_W, default 4, width of step-distance input.
REQ-003 SHALL have parameter BURN_CYCLES, default 1000000, sys_clk cycles a lit candle burns before auto-extinguish.
REQ-004 SHALL have port sys_clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port clr_async  in  1  asynchronous active-high reset.
REQ-006 SHALL have port step  in  1  one-cycle pulse requesting move-then-act.
REQ-007 SHALL have port delta  in  DELTA_W  unsigned move distance, sampled with step.
REQ-008 SHALL have port blow  in  1  one-cycle pulse, extinguish all candles.
REQ-009 SHALL have port ready  out  1  high when step is accepted.
REQ-010 SHALL have port position  out  $clog2(N_CANDLES)  current igniter index.
REQ-011 SHALL have port candle_state  out  N_CANDLES  bit i high = candle i lit.
REQ-012 SHALL have port lit_count  out  $clog2(N_CANDLES+1)  number of lit candles.

Function
REQ-013 SHALL implement FSM IDLE -> MOVE -> ACT -> IDLE, one cycle per state outside IDLE.
REQ-014 SHALL drive ready high only in IDLE; step with ready low SHALL be ignored, not queued.
REQ-015 SHALL in IDLE on step capture delta and enter MOVE.
REQ-016 SHALL in MOVE set position to (position + delta) mod N_CANDLES, exact for non-power-of-2 N_CANDLES and any delta value.
REQ-017 SHALL in ACT toggle candle at position: unlit -> lit (burn timer loaded), lit -> extinguished.
REQ-018 SHALL make position visible one cycle after step and candle_state change two cycles after step.
REQ-019 SHALL on blow clear all candle_state bits and timers next cycle in any FSM state; FSM sequence continues.
REQ-020 SHALL give blow priority over ACT lighting in the same cycle: candle stays unlit.
REQ-021 SHALL drive lit_count combinationally as popcount of candle_state.
REQ-022 SHALL apply timer expiry and ACT on different candles in the same cycle independently.
REQ-023 SHALL, when expiry and ACT hit the same lit candle in one cycle, leave it extinguished.

Reset
REQ-024 SHALL on clr_async high asynchronously force FSM=IDLE, position=0, candle_state=0, timers=0, ready=1, lit_count=0.
REQ-025 SHALL abort any in-flight step on reset mid-operation with no candle update after release.

Configuration
REQ-026 SHALL with CANDLE_BURN_TIMEOUT_EN defined decrement each lit candle's timer every cycle and clear the candle on the cycle its count reaches 0 (lit exactly BURN_CYCLES cycles).
REQ-027 SHALL without CANDLE_BURN_TIMEOUT_EN omit all timers; candles clear only via ACT toggle, blow or reset.

Structure
REQ-028 SHALL place FSM enum ctrl_state_t {IDLE, MOVE, ACT} and default parameter constants in shared package candle_pkg.
REQ-029 SHALL use sub-module candle_burn_timer (load, clear, expire) instantiated N_CANDLES times, only under CANDLE_BURN_TIMEOUT_EN.

Verification
REQ-030 SHALL cover reset then step, delta=3 (N=8) -> position=3 at t+1, candle_state=8'h08 at t+2, lit_count=1.
REQ-031 SHALL cover N=5, position=4, step delta=13 -> position=2 (wrap mod 5).
REQ-032 SHALL cover step delta=0 twice on candle 0 -> lit, then extinguished; second step while ready=0 ignored.
REQ-033 SHALL cover macro on, BURN_CYCLES=20, light candle 1 -> bit 1 clears exactly 20 cycles after lighting.
REQ-034 SHALL cover blow in same cycle as ACT lighting candle 5 with candles 0,2 lit -> candle_state=0.
REQ-035 SHALL cover clr_async asserted during MOVE -> all outputs at reset values immediately, no candle lit after release.
